single_port_ram_ctl: RTL and testbench
======================================

Name: single_port_ram_ctl

Overview:
Initiator-side controller for the 16-bit single-port RAM block.
- Accepts 32-bit word read/write requests with 4 byte enables from the MCU data bus.
- Splits each request into two sequential 16-bit RAM accesses, low half first.
- Handles the RAM's one-cycle registered read latency, reassembles the read word and returns a one-cycle response/ack pulse.

Parameters:
ADDR_WIDTH, 14, RAM halfword address width; the request word address is ADDR_WIDTH-1 bits.
DATA_WIDTH, 16, RAM data width; fixed at 16, any other value is a elaboration error.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_addr  input  ADDR_WIDTH-1  32-bit word address
req_we  input  1  1 = write, 0 = read
req_be  input  4  byte enables, bit i covers req_wdata[8i+7:8i]
req_wdata  input  32  write data
rsp_valid  output  1  one-cycle completion pulse (read data valid or write ack)
rsp_rdata  output  32  read data
init_done  output  1  RAM usable
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_din  output  16  to RAM din
ram_write_en  output  2  to RAM byte write enables
ram_dout  input  16  from RAM dout, valid the cycle after the address is presented

Behaviour:
Reset values:
- req_ready=0, rsp_valid=0, rsp_rdata=0, ram_addr=0, ram_din=0, ram_write_en=0, state=INIT.
- init_done reset value depends on the optional feature.

States: INIT, IDLE, LO, HI, FIN.

INIT:
- Without the feature, INIT goes to IDLE on the first clock.
- With the feature, see Optional Feature.

IDLE:
- req_ready=1.
- On req_valid && req_ready, latch addr/we/be/wdata and go to LO. Otherwise stay.

LO (one cycle):
- ram_addr={addr,1'b0}, ram_din=wdata[15:0].
- ram_write_en = we ? be[1:0] : 2'b00.
- req_ready=0.

HI (one cycle):
- ram_addr={addr,1'b1}, ram_din=wdata[31:16].
- ram_write_en = we ? be[3:2] : 2'b00.
- At the end of the cycle, capture ram_dout (low half) into lo_q.

FIN (one cycle):
- ram_write_en=0.
- At the end of the cycle: rsp_rdata <= we ? rsp_rdata : {ram_dout, lo_q}; rsp_valid <= 1; go to IDLE.

Timing:
- rsp_valid is high for exactly one cycle, three edges after the accept edge.
- Throughput is one request per 4 cycles.
- A new request may be accepted in the same cycle rsp_valid is high.

Edge cases:
- Writes with be=0 still run LO/HI/FIN, write nothing, and ack.
- rsp_rdata holds its value between reads and is unchanged by writes.
- Requests presented while req_ready=0 are ignored; the requester must hold them.
- ram_write_en is 0 outside LO/HI/INIT-sweep.
- ram_addr and ram_din return to 0 in IDLE.
- reset_n assertion at any point aborts the access; an in-flight write may have committed its low half only.

Optional Feature:
Macro: SINGLE_PORT_RAM_CTL_ZERO_INIT_EN

Defined:
- init_done resets to 0.
- INIT sweeps ram_addr 0..2^ADDR_WIDTH-1, one address per cycle, with ram_write_en=2'b11 and ram_din=0.
- After the last address: ram_write_en=0, init_done=1, go to IDLE.
- req_ready stays 0 throughout the sweep.
- Reset mid-sweep restarts from address 0.

Undefined:
- init_done resets to 1.
- INIT lasts one cycle with no RAM writes.

Decomposition:
Package single_port_ram_ctl_pkg holds:
- the state enum (INIT, IDLE, LO, HI, FIN)
- the BE_WIDTH=4 and WORD_WIDTH=32 constants

No sub-module. The init sweep counter reuses ram_addr and stays inline.

Test Plan:
1. Post-reset, feature off: init_done=1 and req_ready=1 within 1 cycle. Feature on, ADDR_WIDTH=4: exactly 16 writes of 0 to addresses 0..15, then init_done=1.
2. Write addr=0x005, be=4'hF, wdata=0xDEADBEEF → RAM writes 0xBEEF at 0x00A with we=2'b11, then 0xDEAD at 0x00B. rsp_valid pulses on edge 3.
3. Read addr=0x005 after test 2 → rsp_rdata=0xDEADBEEF with rsp_valid on edge 3 after accept. ram_write_en stays 0 throughout.
4. Partial write be=4'b0110, wdata=0x11223344 to addr 0x005, then read → 0xDE2233EF. ram_write_en is 2'b10 in LO and 2'b01 in HI.
5. Back-to-back: req_valid held high for 3 requests → accepts exactly every 4 cycles. Each rsp_valid is 1 cycle wide and coincides with the next accept.
6. Assert reset_n low during HI of a write → all outputs return to reset values asynchronously. A subsequent read of the high half returns the old data.

Source files
------------

// File: rtl/single_port_ram_ctl_pkg.sv
// Shared types and constants for the 32-bit-word to 16-bit-RAM access controller.
package single_port_ram_ctl_pkg;

   localparam int BE_WIDTH   = 4;
   localparam int WORD_WIDTH = 32;

   typedef enum logic [2:0] {
      INIT = 3'd0,
      IDLE = 3'd1,
      LO   = 3'd2,
      HI   = 3'd3,
      FIN  = 3'd4
   } state_t;

endpackage

// File: rtl/single_port_ram_ctl.sv
// Splits 32-bit word requests into two 16-bit RAM accesses (low half first).
// Optional macro SINGLE_PORT_RAM_CTL_ZERO_INIT_EN zero-fills the RAM after reset.
//
// state | meaning
// INIT  | post-reset; with zero-init, sweeps every RAM address writing 0
// IDLE  | ready for a request; RAM bus parked at 0
// LO    | low halfword access at {addr,0}
// HI    | high halfword access at {addr,1}; low read data arrives
// FIN   | high read data arrives; response issued at end of cycle
module single_port_ram_ctl
   import single_port_ram_ctl_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-2:0] req_addr,
   input  logic                  req_we,
   input  logic [BE_WIDTH-1:0]   req_be,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [WORD_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic [1:0]            ram_write_en,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   if (DATA_WIDTH != 16) begin : g_bad_data_width
      $error("single_port_ram_ctl: DATA_WIDTH must be 16");
   end

   state_t                state, next_state;
   logic                  accept;
   logic [ADDR_WIDTH-2:0] addr_q;
   logic                  we_q;
   logic [1:0]            be_hi_q;
   logic [DATA_WIDTH-1:0] wdata_hi_q;
   logic [DATA_WIDTH-1:0] lo_q;
   logic [ADDR_WIDTH-1:0] ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_din_d;
   logic [1:0]            ram_write_en_d;

   assign accept = req_valid && req_ready;

`ifdef SINGLE_PORT_RAM_CTL_ZERO_INIT_EN
   // ram_addr doubles as the sweep counter; ram_write_en==0 marks the first sweep cycle
   logic sweep_last;
   assign sweep_last = (ram_write_en == 2'b11) && (ram_addr == {ADDR_WIDTH{1'b1}});
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= INIT;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
`ifdef SINGLE_PORT_RAM_CTL_ZERO_INIT_EN
         INIT:    if (sweep_last) next_state = IDLE;
`else
         INIT:    next_state = IDLE;
`endif
         IDLE:    if (accept) next_state = LO;
         LO:      next_state = HI;
         HI:      next_state = FIN;
         FIN:     next_state = IDLE;
         default: next_state = INIT;
      endcase
   end

   // RAM bus values are computed one cycle ahead and registered
   always_comb begin
      req_ready      = (state == IDLE);
      ram_addr_d     = '0;
      ram_din_d      = '0;
      ram_write_en_d = 2'b00;
      case (state)
         INIT: begin
`ifdef SINGLE_PORT_RAM_CTL_ZERO_INIT_EN
            if (ram_write_en == 2'b00) begin
               ram_write_en_d = 2'b11;
            end else if (!sweep_last) begin
               ram_addr_d     = ram_addr + 1'b1;
               ram_write_en_d = 2'b11;
            end
`endif
         end
         IDLE: begin
            if (accept) begin
               ram_addr_d     = {req_addr, 1'b0};
               ram_din_d      = req_wdata[15:0];
               ram_write_en_d = req_we ? req_be[1:0] : 2'b00;
            end
         end
         LO: begin
            ram_addr_d     = {addr_q, 1'b1};
            ram_din_d      = wdata_hi_q;
            ram_write_en_d = we_q ? be_hi_q : 2'b00;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_addr     <= '0;
         ram_din      <= '0;
         ram_write_en <= 2'b00;
         addr_q       <= '0;
         we_q         <= 1'b0;
         be_hi_q      <= 2'b00;
         wdata_hi_q   <= '0;
         lo_q         <= '0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
      end else begin
         ram_addr     <= ram_addr_d;
         ram_din      <= ram_din_d;
         ram_write_en <= ram_write_en_d;
         if (accept) begin
            addr_q     <= req_addr;
            we_q       <= req_we;
            be_hi_q    <= req_be[3:2];
            wdata_hi_q <= req_wdata[31:16];
         end
         if (state == HI) lo_q <= ram_dout;
         rsp_valid <= (state == FIN);
         if (state == FIN && !we_q) rsp_rdata <= {ram_dout, lo_q};
      end
   end

`ifdef SINGLE_PORT_RAM_CTL_ZERO_INIT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          init_done <= 1'b0;
      else if (state == INIT && sweep_last)  init_done <= 1'b1;
   end
`else
   assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_single_port_ram_ctl.sv
// Randomized scoreboard bench for single_port_ram_ctl with a word-level memory model.
module tb_single_port_ram_ctl;

`ifdef SINGLE_PORT_RAM_CTL_ZERO_INIT_EN
   localparam int AW = 4;
`else
   localparam int AW = 14;
`endif
   localparam int NH = 2 ** AW;
   localparam int NW = 2 ** (AW - 1);

   logic          clk;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [AW-2:0] req_addr;
   logic          req_we;
   logic [3:0]    req_be;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          init_done;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_din;
   logic [1:0]    ram_write_en;
   logic [15:0]   ram_dout;

   single_port_ram_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_write_en(ram_write_en),
      .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 16-bit RAM with byte write enables and one-cycle registered read
   logic [15:0] ram [NH];
   initial begin
      for (int i = 0; i < NH; i++) ram[i] = 16'h0000;
      ram_dout = 16'h0000;
   end
   always @(posedge clk) begin
      if (ram_write_en[0]) ram[ram_addr][7:0]  <= ram_din[7:0];
      if (ram_write_en[1]) ram[ram_addr][15:8] <= ram_din[15:8];
      ram_dout <= ram[ram_addr];
   end

   typedef struct {
      int          due;
      logic [31:0] rdata;
   } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_ref [NW];
   logic [31:0] last_rd = 32'h0;
   int          last_acc = 0;
   logic        rsp_at_acc = 1'b0;

   initial for (int i = 0; i < NW; i++) mem_ref[i] = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && rsp_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response pending");
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_cycle", 32'(cyc), 32'(e.due));
            chk("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] m;
      m = old;
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
      return m;
   endfunction

   task automatic do_req(input logic we, input logic [AW-2:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input bit abort);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_be    = be;
      req_wdata = wd;
      while (!req_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 60 cycles");
         req_valid = 1'b0;
         return;
      end
      last_acc   = cyc + 1;
      rsp_at_acc = rsp_valid;
      e.due      = cyc + 4;
      if (!we) last_rd = mem_ref[a];
      e.rdata = last_rd;
      sbq.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("lo_addr", 32'(ram_addr), 32'({a, 1'b0}));
      chk("lo_we", 32'(ram_write_en), 32'(we ? be[1:0] : 2'b00));
      if (we) chk("lo_din", 32'(ram_din), 32'(wd[15:0]));
      if (abort) begin
         @(posedge clk);
         #2 reset_n = 1'b0;
         #1;
         chk("abort_req_ready", 32'(req_ready), 32'h0);
         chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("abort_rsp_rdata", rsp_rdata, 32'h0);
         chk("abort_ram_addr", 32'(ram_addr), 32'h0);
         chk("abort_ram_din", 32'(ram_din), 32'h0);
         chk("abort_ram_we", 32'(ram_write_en), 32'h0);
         void'(sbq.pop_back());
         if (we) mem_ref[a] = merge(mem_ref[a], wd, be & 4'b0011);
         last_rd = 32'h0;
`ifdef SINGLE_PORT_RAM_CTL_ZERO_INIT_EN
         for (int i = 0; i < NW; i++) mem_ref[i] = 32'h0;
`endif
         @(negedge clk);
         reset_n = 1'b1;
         return;
      end
      @(negedge clk);
      chk("hi_addr", 32'(ram_addr), 32'({a, 1'b1}));
      chk("hi_we", 32'(ram_write_en), 32'(we ? be[3:2] : 2'b00));
      if (we) chk("hi_din", 32'(ram_din), 32'(wd[31:16]));
      if (we) mem_ref[a] = merge(mem_ref[a], wd, be);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc[3];
      int cnt;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_be    = 4'h0;
      req_wdata = 32'h0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_din", 32'(ram_din), 32'h0);
      chk("rst_ram_we", 32'(ram_write_en), 32'h0);
`ifdef SINGLE_PORT_RAM_CTL_ZERO_INIT_EN
      chk("rst_init_done", 32'(init_done), 32'h0);
`else
      chk("rst_init_done", 32'(init_done), 32'h1);
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

`ifdef SINGLE_PORT_RAM_CTL_ZERO_INIT_EN
      cnt = 0;
      for (int i = 0; i < NH + 10; i++) begin
         @(negedge clk);
         if (ram_write_en != 2'b00) begin
            chk("init_we", 32'(ram_write_en), 32'h3);
            chk("init_din", 32'(ram_din), 32'h0);
            chk("init_addr", 32'(ram_addr), 32'(cnt));
            chk("init_ready_low", 32'(req_ready), 32'h0);
            cnt++;
         end
         if (init_done) break;
      end
      chk("init_writes", 32'(cnt), 32'(NH));
      chk("init_done", 32'(init_done), 32'h1);
`else
      @(negedge clk);
      chk("init_done", 32'(init_done), 32'h1);
      chk("init_ready", 32'(req_ready), 32'h1);
`endif

      do_req(1'b1, (AW-1)'(5), 4'hF, 32'hDEADBEEF, 1'b0);
      do_req(1'b0, (AW-1)'(5), 4'h0, 32'h0, 1'b0);
      do_req(1'b1, (AW-1)'(5), 4'b0110, 32'h11223344, 1'b0);
      do_req(1'b0, (AW-1)'(5), 4'h0, 32'h0, 1'b0);
      do_req(1'b1, (AW-1)'(3), 4'h0, 32'hFFFFFFFF, 1'b0);
      do_req(1'b0, (AW-1)'(3), 4'h0, 32'h0, 1'b0);

      for (int k = 0; k < 3; k++) begin
         do_req(1'b1, (AW-1)'(k + 1), 4'hF, $urandom, 1'b0);
         acc[k] = last_acc;
         if (k > 0) begin
            chk("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'h4);
            chk("b2b_rsp_with_accept", 32'(rsp_at_acc), 32'h1);
         end
      end

      for (int k = 0; k < 40; k++) begin
         do_req(1'($urandom_range(0, 1)), (AW-1)'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), $urandom, 1'b0);
      end

      do_req(1'b1, (AW-1)'(5), 4'hF, 32'hCAFEF00D, 1'b1);
      do_req(1'b0, (AW-1)'(5), 4'h0, 32'h0, 1'b0);
      do_req(1'b0, (AW-1)'(3), 4'h0, 32'h0, 1'b0);

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_missing: got %0d pending expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
